// File: rtl/fetch_pkg.sv
// Shared types for the fetch queue slice.
// Entry layout, FSM states and default depth.
package fetch_pkg;

  typedef enum logic [1:0] {
    FQ_REQ,
    FQ_WAIT,
    FQ_DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int FQ_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries.
// One push, up to two pops, clear, two read views.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic [1:0]   pop,
  output fetch_entry_t rdata0,
  output fetch_entry_t rdata1,
  output logic [CW-1:0] count
);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] head_nxt;
  logic [1:0]    pop_lim;
  logic [1:0]    pop_eff;

  // Clamp the pop request to 2 and to the current occupancy.
  always_comb begin
    pop_lim = (pop > 2'd2) ? 2'd2 : pop;
    pop_eff = pop_lim;
    if (CW'(pop_lim) > count) pop_eff = count[1:0];
  end

  // Pointer and occupancy update; clear and reset both empty the queue.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(pop_eff);
      tail  <= tail + AW'(push);
      count <= count + CW'(push) - CW'(pop_eff);
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (rst_n && !clear && push) mem[tail] <= wdata;
  end

  assign head_nxt = head + AW'(1);
  assign rdata0   = mem[head];
  assign rdata1   = mem[head_nxt];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-stage instruction queue between PC register and Decode.
// One outstanding imem request; stalls PC until the word returns.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Flush,
  input  logic [31:0]   PC,
  output logic          Stall,
  output logic          IMemReq,
  output logic [31:0]   IMemAddr,
  input  logic          IMemReady,
  input  logic          IMemValid,
  input  logic [31:0]   IMemData,
  input  logic [1:0]    DecodePop,
  output logic          Valid0,
  output logic          Valid1,
  output logic [31:0]   PC0,
  output logic [31:0]   Instr0,
  output logic [31:0]   PC1,
  output logic [31:0]   Instr1,
  output logic [CW-1:0] Count
);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [31:0]   req_pc;
  logic          push;
  logic          issue;
  logic [CW-1:0] cnt;
  fetch_entry_t  wdata;
  fetch_entry_t  rd0;
  fetch_entry_t  rd1;

  // Next state, request and stall; a slot is reserved before issuing.
  always_comb begin
    state_nxt = state;
    IMemReq   = 1'b0;
    Stall     = 1'b1;
    push      = 1'b0;
    if (reset) begin
      unique case (state)
        FQ_REQ: begin
          IMemReq = (cnt < CW'(DEPTH)) && !Flush;
          if (IMemReq && IMemReady) state_nxt = FQ_WAIT;
        end
        FQ_WAIT: begin
          if (IMemValid) begin
            state_nxt = FQ_REQ;
            if (!Flush) begin
              push  = 1'b1;
              Stall = 1'b0;
            end
          end else if (Flush) begin
            state_nxt = FQ_DRAIN;
          end
        end
        FQ_DRAIN: begin
          if (IMemValid) state_nxt = FQ_REQ;
        end
        default: state_nxt = FQ_REQ;
      endcase
    end
  end

  assign issue = (state == FQ_REQ) && IMemReq && IMemReady;

  // State register and address of the outstanding request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= FQ_REQ;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      if (issue) req_pc <= PC;
    end
  end

  assign wdata = '{pc: req_pc, instr: IMemData};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (Flush),
    .push   (push),
    .wdata  (wdata),
    .pop    (DecodePop),
    .rdata0 (rd0),
    .rdata1 (rd1),
    .count  (cnt)
  );

  assign IMemAddr = PC;
  assign Count    = reset ? cnt : '0;
  assign Valid0   = reset && (cnt >= CW'(1));
  assign Valid1   = reset && (cnt >= CW'(2));
  assign PC0      = rd0.pc;
  assign Instr0   = rd0.instr;
  assign PC1      = rd1.pc;
  assign Instr1   = rd1.instr;

endmodule
